// File: rtl/dcp_pkg.sv
// ============================================================================
// Module   : dcp_pkg
// Brief    : Shared Cohort tile types: page numbers and micro-TLB FSM states.
// Revision : 1.0
// ============================================================================
`ifndef DCP_VADDR
`define DCP_VADDR 32
`endif
`default_nettype none

package dcp_pkg;

  typedef logic [`DCP_VADDR-12-1:0] vpn_t;
  typedef vpn_t ppn_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } utlb_state_e;

endpackage

`default_nettype wire

// File: rtl/cohort_utlb_cam.sv
// ============================================================================
// Module   : cohort_utlb_cam
// Brief    : Fully-associative tag compare with lowest-index hit/free encoders.
// Revision : 1.0
// ============================================================================
`ifndef DCP_VADDR
`define DCP_VADDR 32
`endif
`default_nettype none

module cohort_utlb_cam
  import dcp_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = `DCP_VADDR-12
) (
  input  logic [ENTRIES-1:0]                valid,
  input  logic [ENTRIES-1:0][VPN_W-1:0]     tags,
  input  logic [VPN_W-1:0]                  vpn,
  output logic                              hit,
  output logic [$clog2(ENTRIES)-1:0]        hit_idx,
  output logic [$clog2(ENTRIES)-1:0]        first_free,
  output logic                              any_free
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] w_match;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign w_match[gi] = valid[gi] && (tags[gi] == vpn);
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit_idx    = '0;
    first_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) hit_idx = i[IDX_W-1:0];
      if (!valid[i])  first_free = i[IDX_W-1:0];
    end
  end

  assign hit      = |w_match;
  assign any_free = ~&valid;

endmodule

`default_nettype wire

// File: rtl/cohort_utlb.sv
// ============================================================================
// Module   : cohort_utlb
// Brief    : Micro-TLB in front of the shared TLB port; one outstanding miss.
// Revision : 1.0
// ============================================================================
`ifndef DCP_VADDR
`define DCP_VADDR 32
`endif
`default_nettype none

module cohort_utlb
  import dcp_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = `DCP_VADDR-12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             req_ack,
  output logic [VPN_W-1:0] req_ppn,
  output logic             tlb_valid,
  output logic [VPN_W-1:0] tlb_vpn,
  input  logic             tlb_ack,
  input  logic [VPN_W-1:0] tlb_ppn,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  utlb_state_e                  r_state, w_next;
  logic [ENTRIES-1:0]           r_valid;
  logic [ENTRIES-1:0][VPN_W-1:0] r_tag;
  logic [ENTRIES-1:0][VPN_W-1:0] r_ppn;
  logic [IDX_W-1:0]             r_ptr;
  logic                         r_drop;

  logic             w_hit, w_any_free;
  logic [IDX_W-1:0] w_hit_idx, w_first_free, w_victim;
  logic             w_lookup_hit, w_lookup_miss, w_fill, w_install;

  cohort_utlb_cam #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W)
  ) u_cam (
    .valid      (r_valid),
    .tags       (r_tag),
    .vpn        (req_vpn),
    .hit        (w_hit),
    .hit_idx    (w_hit_idx),
    .first_free (w_first_free),
    .any_free   (w_any_free)
  );

  // A flush coinciding with a lookup must not return a translation it is invalidating.
  always_comb begin
    w_next        = r_state;
    w_lookup_hit  = 1'b0;
    w_lookup_miss = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_hit && !flush) begin
            w_lookup_hit = 1'b1;
            w_next       = RESP;
          end else begin
            w_lookup_miss = 1'b1;
            w_next        = MISS;
          end
        end
      end
      MISS: begin
        if (tlb_ack) begin
          w_fill = 1'b1;
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_install = w_fill && !r_drop && !flush;
  assign w_victim  = w_any_free ? w_first_free : r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack   <= 1'b0;
      req_ppn   <= '0;
      tlb_valid <= 1'b0;
      tlb_vpn   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      r_valid   <= '0;
      r_tag     <= '0;
      r_ppn     <= '0;
      r_ptr     <= '0;
      r_drop    <= 1'b0;
    end else begin
      req_ack <= w_lookup_hit || w_fill;
      if (w_lookup_hit) req_ppn <= r_ppn[w_hit_idx];
      if (w_fill)       req_ppn <= tlb_ppn;

      if (w_lookup_miss) begin
        tlb_valid <= 1'b1;
        tlb_vpn   <= req_vpn;
      end else if (w_fill) begin
        tlb_valid <= 1'b0;
      end

      if (w_lookup_hit)  hit_cnt  <= hit_cnt + 16'd1;
      if (w_lookup_miss) miss_cnt <= miss_cnt + 16'd1;

      if (w_fill)                         r_drop <= 1'b0;
      else if (r_state == MISS && flush)  r_drop <= 1'b1;

      if (flush) begin
        r_valid <= '0;
        r_ptr   <= '0;
      end else if (w_install) begin
        r_valid[w_victim] <= 1'b1;
        r_tag[w_victim]   <= tlb_vpn;
        r_ppn[w_victim]   <= tlb_ppn;
        if (!w_any_free) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
